mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port `memory` block between two independent requesters (e.g. a host agent and a scrub/init engine). Each requester issues one read or write at a time over a valid/ready handshake. The arbiter picks a winner, sequences the command onto the memory's `addr/wr_en/rd_en/wdata` pins, and returns read data or a write acknowledgement on a per-requester response pulse. It sits between the requesters and `memory`, inside the same DUT boundary that `mem_intf` connects to.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory over a valid/ready handshake.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins), else round-robin.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_wr,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wr_en,
    output logic                    mem_rd_en,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [1:0] LastCnt = 2'(RD_LATENCY - 1);

    state_e                  state_q, state_d;
    logic                    owner_q;
    logic                    cmd_wr_q;
    logic [1:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    grant;
    logic                    accept;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign grant = ~req_valid[0];
`else
    logic last_grant_q;

    // On a tie the requester that did not win last time gets the grant.
    assign grant = (&req_valid) ? ~last_grant_q : ~req_valid[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant;
        end
    end
`endif

    assign accept = reset && (state_q == StIdle) && (|req_valid);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req_valid) state_d = StIssue;
            StIssue: state_d = cmd_wr_q ? StResp : StWait;
            StWait:  if (cnt_q == LastCnt) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q  <= 1'b0;
            cmd_wr_q <= 1'b0;
            cnt_q    <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            // The captured command doubles as the held memory address/data.
            if (accept) begin
                owner_q  <= grant;
                cmd_wr_q <= grant ? req_wr[1] : req_wr[0];
                addr_q   <= grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : req_addr[ADDR_WIDTH-1:0];
                wdata_q  <= grant ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : req_wdata[DATA_WIDTH-1:0];
            end
            if (state_q == StIssue) begin
                cnt_q <= 2'd0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if ((state_q == StWait) && (cnt_q == LastCnt)) begin
                rdata_q <= mem_rdata;
            end else if ((state_q == StIssue) && cmd_wr_q) begin
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (accept) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
        rsp_valid = 2'b00;
        if (state_q == StResp) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
        end
        mem_wr_en = (state_q == StIssue) && cmd_wr_q;
        mem_rd_en = (state_q == StIssue) && !cmd_wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rsp_rdata = rdata_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed vectors, expected responses queued at accept
// and popped by a monitor on every rsp_valid pulse. A second instance covers RD_LATENCY=3.
module tb_mem_arbiter;

    typedef struct {
        logic [1:0] vld;
        logic [7:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_valid3, req_wr;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready, rsp_valid, req_ready3, rsp_valid3;
    logic [7:0]  rsp_rdata, mem_wdata, mem_rdata, rsp_rdata3, mem_wdata3, mem_rdata3;
    logic [1:0]  mem_addr, mem_addr3;
    logic        mem_wr_en, mem_rd_en, busy, mem_wr_en3, mem_rd_en3, busy3;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] shadow [4];
    logic [7:0] mem_a [4];
    logic [7:0] mem_b [4];
    logic [7:0] pipe_a;
    logic [7:0] pipe_b [3];
    int   exp_gr [4];
    int   grants [4];

    always #5 clk = ~clk;

    mem_arbiter u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.RD_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .mem_addr(mem_addr3),
        .mem_wr_en(mem_wr_en3), .mem_rd_en(mem_rd_en3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3), .busy(busy3)
    );

    // Memory models: read data appears RD_LATENCY cycles after the rd_en cycle.
    always @(posedge clk) begin
        if (mem_wr_en) mem_a[mem_addr] <= mem_wdata;
        pipe_a    <= mem_rd_en ? mem_a[mem_addr] : 8'hEE;
        pipe_b[0] <= mem_rd_en3 ? mem_b[mem_addr3] : 8'hEE;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign mem_rdata  = pipe_a;
    assign mem_rdata3 = pipe_b[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b, expected none", rsp_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_owner", 32'(rsp_valid), 32'(mon_e.vld));
                check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
            end
        end
    end

    task automatic do_req(input int i, input logic wr, input logic [1:0] addr,
                          input logic [7:0] wd);
        exp_t e;
        int   waited = 0;
        logic got = 1'b0;
        tick();
        req_wr[i] = wr;
        req_addr[i*2 +: 2] = addr;
        req_wdata[i*8 +: 8] = wd;
        req_valid[i] = 1'b1;
        while (!got && waited < 20) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
            else begin
                tick();
                waited++;
            end
        end
        check("accept_seen", 32'(got), 32'd1);
        if (!got) begin
            req_valid[i] = 1'b0;
            return;
        end
        check("ready_grant", 32'(req_ready), 32'(2'b01 << i));
        e.vld   = 2'(2'b01 << i);
        e.rdata = wr ? 8'h00 : shadow[addr];
        if (wr) shadow[addr] = wd;
        exp_q.push_back(e);
        tick();
        req_valid[i] = 1'b0;
        @(negedge clk);
        check("issue_wr_en", 32'(mem_wr_en), 32'(wr));
        check("issue_rd_en", 32'(mem_rd_en), 32'(!wr));
        check("issue_addr", 32'(mem_addr), 32'(addr));
        check("issue_busy", 32'(busy), 32'd1);
        if (wr) check("issue_wdata", 32'(mem_wdata), 32'(wd));
        repeat (wr ? 1 : 2) tick();
        @(negedge clk);
        check("rsp_timing", 32'(rsp_valid), 32'(2'b01 << i));
        tick();
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int accepts;
        for (int a = 0; a < 4; a++) begin
            mem_a[a]  = 8'h10 + 8'(a);
            mem_b[a]  = 8'h10 + 8'(a);
            shadow[a] = 8'h10 + 8'(a);
        end
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_gr = '{0, 0, 0, 0};
`else
        exp_gr = '{0, 1, 0, 1};
`endif
        reset = 1'b0;
        req_valid = 2'b00; req_valid3 = 2'b00; req_wr = 2'b00;
        req_addr = '0; req_wdata = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_outputs", {req_ready, rsp_valid, mem_addr, mem_wr_en, mem_rd_en, busy},
              32'd0);
        check("rst_data", {mem_wdata, rsp_rdata}, 32'd0);
        tick();
        reset = 1'b1;

        // Single write then read-back from the other requester.
        do_req(0, 1'b1, 2'd2, 8'hA5);
        do_req(1, 1'b0, 2'd2, 8'h00);

        // Contention after a fresh reset: both hold reads for four grants.
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req_wr = 2'b00;
        req_addr = {2'd1, 2'd0};
        req_valid = 2'b11;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                exp_t e;
                check("rr_onehot", 32'($onehot(req_ready)), 32'd1);
                grants[n] = req_ready[1] ? 1 : 0;
                e.vld = req_ready;
                e.rdata = shadow[req_ready[1] ? 1 : 0];
                exp_q.push_back(e);
                n++;
            end
            tick();
            if (n == 4) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        check("rr_count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) check("rr_order", 32'(grants[k]), 32'(exp_gr[k]));
        repeat (5) tick();

        // Stall: req0 waits while req1's write is in flight; accepted exactly once.
        req_wr = 2'b10;
        req_addr = {2'd1, 2'd1};
        req_wdata = {8'h5C, 8'h00};
        req_valid = 2'b10;
        @(negedge clk);
        check("stall_first", 32'(req_ready), 32'(2'b10));
        begin
            exp_t e;
            e.vld = 2'b10; e.rdata = 8'h00;
            exp_q.push_back(e);
            shadow[1] = 8'h5C;
        end
        tick();
        req_wr = 2'b00;
        req_valid = 2'b01;
        accepts = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy) check("stall_ready", 32'(req_ready), 32'd0);
            if (req_ready[0]) begin
                exp_t e;
                e.vld = 2'b01; e.rdata = shadow[1];
                exp_q.push_back(e);
                accepts++;
            end
            tick();
            if (accepts > 0) req_valid = 2'b00;
        end
        check("stall_accepts", 32'(accepts), 32'd1);

        // Reset during WAIT of a req0 read aborts it without a response.
        req_addr = {2'd1, 2'd0};
        req_valid = 2'b01;
        @(negedge clk);
        check("abort_accept", 32'(req_ready), 32'(2'b01));
        tick();
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        tick();
        @(negedge clk);
        check("abort_outputs", {rsp_valid, mem_addr, mem_wr_en, mem_rd_en, busy}, 32'd0);
        check("abort_data", {mem_wdata, rsp_rdata}, 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("abort_regrant", 32'(req_ready), 32'(2'b01));
        begin
            exp_t e;
            e.vld = 2'b01; e.rdata = shadow[0];
            exp_q.push_back(e);
        end
        tick();
        req_valid = 2'b00;
        repeat (5) tick();

        // RD_LATENCY=3 instance: response lands at T+5.
        req_addr = {2'd0, 2'd3};
        req_valid3 = 2'b01;
        @(negedge clk);
        check("l3_ready", 32'(req_ready3), 32'(2'b01));
        tick();
        req_valid3 = 2'b00;
        @(negedge clk);
        check("l3_rd_en", 32'(mem_rd_en3), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        check("l3_early", 32'(rsp_valid3), 32'd0);
        tick();
        @(negedge clk);
        check("l3_rsp", 32'(rsp_valid3), 32'(2'b01));
        check("l3_rdata", 32'(rsp_rdata3), 32'h13);

        repeat (4) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
